// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory-access stage and MEM/WB pipeline register
//
// Performs loads and stores over a variable-latency req/ack data-memory port,
// stalls upstream while an access is outstanding, aligns/extends load data and
// drives the register-file write port.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   valid_m .. PCPlus4M      EX/MEM bundle (held stable while stall_m = 1)
//   stall_m                  upstream must hold the M inputs this cycle
//   dmem_req/we/addr/wdata/wstrb, dmem_ack/rdata   data-memory handshake
//   RegWriteEnW, RDW, ResultW  register-file write port
//   mem_err                  one-cycle pulse on misaligned access or timeout
module mem_wb_stage #(
  parameter int TIMEOUT = 16,
  parameter int XLEN    = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_m,
  input  logic            RegWriteEnM,
  input  logic            MemtoRegM,
  input  logic            JALM,
  input  logic            MemReadEnM,
  input  logic            MemWriteEnM,
  input  logic [1:0]      MemSizeM,
  input  logic [1:0]      LoadSizeM,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic [4:0]      RdM,
  input  logic [XLEN-1:0] PCPlus4M,
  output logic            stall_m,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [7:0]      dmem_wstrb,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            RegWriteEnW,
  output logic [4:0]      RDW,
  output logic [XLEN-1:0] ResultW,
  output logic            mem_err
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            req_q;
  logic [2:0]      off;
  logic            memop;
  logic            misaligned;
  logic            in_access;
  logic            timeout_hit;
  logic            capture;
  logic            err_d;
  logic [7:0]      byte_mask;
  logic [XLEN-1:0] rshift;
  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] result;
  logic            sx;
  logic            store_act;

  assign off         = ALUResultM[2:0];
  assign memop       = valid_m & (MemReadEnM | MemWriteEnM);
  assign in_access   = (state_q == S_ACCESS);
  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  // Natural alignment: the low log2(size) offset bits must be zero.
  always_comb begin
    misaligned = 1'b0;
    byte_mask  = 8'h01;
    case (MemSizeM)
      2'b00: begin misaligned = 1'b0;       byte_mask = 8'h01; end
      2'b01: begin misaligned = off[0];     byte_mask = 8'h03; end
      2'b10: begin misaligned = |off[1:0];  byte_mask = 8'h0F; end
      default: begin misaligned = |off;     byte_mask = 8'hFF; end
    endcase
    misaligned = misaligned & memop;
  end

  // Store lanes are only presented while the request is outstanding.
  assign store_act  = in_access & MemWriteEnM;
  assign dmem_req   = req_q;
  assign dmem_we    = store_act;
  assign dmem_addr  = {ALUResultM[XLEN-1:3], 3'b000};
  assign dmem_wdata = store_act ? (WriteDataM << {off, 3'b000}) : '0;
  assign dmem_wstrb = store_act ? (byte_mask << off) : 8'h00;

  // Load extract: bring the addressed bytes down to bit 0, then extend.
  assign rshift = dmem_rdata >> {off, 3'b000};
  assign sx     = (LoadSizeM != 2'b01);

  always_comb begin
    load_val = rshift;
    case (MemSizeM)
      2'b00:   load_val = {{(XLEN-8){sx & rshift[7]}},   rshift[7:0]};
      2'b01:   load_val = {{(XLEN-16){sx & rshift[15]}}, rshift[15:0]};
      2'b10:   load_val = {{(XLEN-32){sx & rshift[31]}}, rshift[31:0]};
      default: load_val = rshift;
    endcase
  end

  always_comb begin
    if (JALM)           result = PCPlus4M;
    else if (MemtoRegM) result = load_val;
    else                result = ALUResultM;
  end

  // Next-state / stall / W-capture decisions. Ack is tested before the
  // timeout so a completion on the last allowed cycle is still honoured.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_m = 1'b0;
    capture = 1'b0;
    err_d   = 1'b0;
    if (state_q == S_IDLE) begin
      if (memop && !misaligned) begin
        stall_m = 1'b1;
        state_d = S_ACCESS;
        cnt_d   = '0;
      end else if (misaligned) begin
        err_d = 1'b1;
      end else begin
        capture = 1'b1;
      end
    end else begin
      if (dmem_ack) begin
        capture = 1'b1;
        state_d = S_IDLE;
      end else if (timeout_hit) begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end else begin
        stall_m = 1'b1;
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= (state_d == S_ACCESS);
    end
  end

  // W register: a bubble leaves RDW/ResultW untouched and only clears the
  // write enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWriteEnW <= 1'b0;
      RDW         <= '0;
      ResultW     <= '0;
      mem_err     <= 1'b0;
    end else begin
      mem_err <= err_d;
      if (capture) begin
        RegWriteEnW <= RegWriteEnM & valid_m & (RdM != 5'd0);
        RDW         <= RdM;
        ResultW     <= result;
      end else begin
        RegWriteEnW <= 1'b0;
      end
    end
  end

endmodule
